// File: rtl/mat_pkg.sv
// rtl/mat_pkg.sv - shared types and defaults for the matrix row accumulator
package mat_pkg;

  localparam int DW_DEF = 32;
  localparam int N_DEF  = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    RECV  = 2'd2
  } state_t;

  typedef struct packed {
    logic              last;
    logic [DW_DEF-1:0] data;
  } fifo_entry_t;

endpackage

// File: rtl/mat_sum_fifo.sv
// rtl/mat_sum_fifo.sv - synchronous result FIFO reporting empty, full and free entries
module mat_sum_fifo
  import mat_pkg::*;
#(
  parameter int W     = DW_DEF + 1,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  logic [W-1:0]               i_push_data,
  input  logic                       i_pop,
  output logic [W-1:0]               o_pop_data,
  output logic                       o_empty,
  output logic                       o_full,
  output logic [$clog2(DEPTH):0]     o_free
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_do_pop;

  assign o_empty    = (r_count == '0);
  assign o_full     = (r_count == DEPTH_W);
  assign o_free     = DEPTH_W - r_count;
  assign o_pop_data = r_mem[r_rd_ptr];
  assign w_do_pop   = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (i_push) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      // Grant logic reserves space up front, so a push into a full FIFO is a design bug.
      assert (!(i_push && o_full));
      if (i_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({i_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/mat_row_acc.sv
// rtl/mat_row_acc.sv - per-row frame accumulator; MAT_ROW_ACC_SAT_EN enables saturating sums
module mat_row_acc
  import mat_pkg::*;
#(
  parameter int DW         = DW_DEF,
  parameter int N          = N_DEF,
  parameter int FIFO_DEPTH = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_req,
  output logic          in_ack,
  input  logic          in_vld,
  input  logic [DW-1:0] in_data,
  output logic          out_vld,
  input  logic          out_rdy,
  output logic [DW-1:0] out_data,
  output logic          out_last,
  output logic          ovf
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);
  localparam logic [AW:0]   N_W      = (AW+1)'(N);

  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_col;
  logic [CW-1:0] r_row;
  logic [DW-1:0] r_sum;
  logic [DW-1:0] w_base;
  logic [DW-1:0] w_sum_next;
  logic          w_accept;
  logic          w_col_last;
  logic          w_row_last;
  logic          w_push;
  logic [DW:0]   w_push_data;
  logic [DW:0]   w_head;
  logic          w_empty;
  logic          w_full;
  logic [AW:0]   w_free;

  assign w_accept   = (r_state == RECV) && in_vld;
  assign w_col_last = (r_col == LAST_IDX);
  assign w_row_last = (r_row == LAST_IDX);
  assign w_base     = (r_col == '0) ? '0 : r_sum;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    in_ack = 1'b0;
    case (r_state)
      IDLE: begin
        // w_free is the registered count, so a same-cycle pop is not credited.
        if (in_req && !w_full && (w_free >= N_W)) begin
          w_next = GRANT;
        end
      end
      GRANT: begin
        in_ack = 1'b1;
        w_next = RECV;
      end
      RECV: begin
        if (w_accept && w_col_last && w_row_last) begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

`ifdef MAT_ROW_ACC_SAT_EN
  logic [DW:0] w_wide;
  logic        w_sat_hit;
  logic        r_ovf;

  assign w_wide     = {1'b0, w_base} + {1'b0, in_data};
  assign w_sat_hit  = w_wide[DW];
  assign w_sum_next = w_sat_hit ? '1 : w_wide[DW-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (w_accept && w_sat_hit) begin
      r_ovf <= 1'b1;
    end
  end

  assign ovf = r_ovf;
`else
  assign w_sum_next = w_base + in_data;
  assign ovf        = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_col <= '0;
      r_row <= '0;
      r_sum <= '0;
    end else if (w_accept) begin
      if (w_col_last) begin
        r_col <= '0;
        r_row <= w_row_last ? '0 : r_row + 1'b1;
        r_sum <= '0;
      end else begin
        r_col <= r_col + 1'b1;
        r_sum <= w_sum_next;
      end
    end
  end

  assign w_push      = w_accept && w_col_last;
  assign w_push_data = {w_row_last, w_sum_next};

  mat_sum_fifo #(
    .W     (DW + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_push),
    .i_push_data (w_push_data),
    .i_pop       (out_rdy),
    .o_pop_data  (w_head),
    .o_empty     (w_empty),
    .o_full      (w_full),
    .o_free      (w_free)
  );

  // Head storage is not reset, so outputs are masked while the FIFO is empty.
  assign out_vld  = !w_empty;
  assign out_data = w_empty ? '0 : w_head[DW-1:0];
  assign out_last = w_empty ? 1'b0 : w_head[DW];

endmodule
